// File: rtl/merac_pkg.sv
// Shared constants and ALU function encoding for the merac 8-bit CPU datapath.
package merac_pkg;

  localparam int WIDTH_WORD   = 8;
  localparam int WIDTH_SEG    = 4;
  localparam int WIDTH_DOUBLE = 16;
  localparam int ALU_FN_W     = 3;

  // Program counter lives in the register file as a byte pair.
  localparam int REG_PC_LO = 14;
  localparam int REG_PC_HI = 15;

  typedef enum logic [ALU_FN_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_NOT = 3'd3,
    ALU_MV  = 3'd4,
    ALU_AND = 3'd5,
    ALU_EQ  = 3'd6,
    ALU_LT  = 3'd7
  } alu_fn_e;

endpackage

// File: rtl/merac_if.sv
// Sequencer <-> datapath bus: register write ports, read selects/data and ALU controls.
interface merac_if #(
  parameter int WIDTH_WORD = merac_pkg::WIDTH_WORD,
  parameter int WIDTH_SEG  = merac_pkg::WIDTH_SEG
);

  logic                  write0;
  logic                  write1;
  logic [WIDTH_SEG-1:0]  srcreg0;
  logic [WIDTH_WORD-1:0] srcval0;
  logic [WIDTH_SEG-1:0]  srcreg1;
  logic [WIDTH_WORD-1:0] srcval1;
  logic [WIDTH_SEG-1:0]  dstreg0;
  logic [WIDTH_SEG-1:0]  dstreg1;
  logic [WIDTH_WORD-1:0] dstval0;
  logic [WIDTH_WORD-1:0] dstval1;
  logic                  alu_en;
  logic [2:0]            alu_fn;
  logic [WIDTH_WORD-1:0] retval;
  logic                  carry;

  modport master (
    output write0, write1, srcreg0, srcval0, srcreg1, srcval1,
    output dstreg0, dstreg1, alu_en, alu_fn,
    input  dstval0, dstval1, retval, carry
  );

  modport slave (
    input  write0, write1, srcreg0, srcval0, srcreg1, srcval1,
    input  dstreg0, dstreg1, alu_en, alu_fn,
    output dstval0, dstval1, retval, carry
  );

endinterface

// File: rtl/merac_alu.sv
// Combinational ALU of the merac datapath; carry is only meaningful for ADD/SUB.
module merac_alu #(
  parameter int WIDTH_WORD = merac_pkg::WIDTH_WORD
) (
  input  logic                  alu_en,
  input  logic [2:0]            alu_fn,
  input  logic [WIDTH_WORD-1:0] a,
  input  logic [WIDTH_WORD-1:0] b,
  output logic [WIDTH_WORD-1:0] retval,
  output logic                  carry
);
  import merac_pkg::*;

  alu_fn_e               fn;
  logic [WIDTH_WORD:0]   sum;
  logic [WIDTH_WORD:0]   diff;

  assign fn = alu_fn_e'(alu_fn);

  always_comb begin
    retval = '0;
    carry  = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    // The extra top bit of the widened difference is the unsigned borrow.
    diff   = {1'b0, a} - {1'b0, b};
    if (alu_en) begin
      case (fn)
        ALU_ADD: begin
          retval = sum[WIDTH_WORD-1:0];
          carry  = sum[WIDTH_WORD];
        end
        ALU_SUB: begin
          retval = diff[WIDTH_WORD-1:0];
          carry  = diff[WIDTH_WORD];
        end
        ALU_OR:  retval = a | b;
        ALU_NOT: retval = ~a;
        ALU_MV:  retval = a;
        ALU_AND: retval = a & b;
        ALU_EQ:  retval = {{(WIDTH_WORD-1){1'b0}}, (a == b)};
        ALU_LT:  retval = {{(WIDTH_WORD-1){1'b0}}, (a < b)};
        default: retval = '0;
      endcase
    end
  end

endmodule

// File: rtl/merac_datapath.sv
// merac execution datapath: 16-entry dual-write/dual-read register file feeding the ALU.
module merac_datapath #(
  parameter int WIDTH_WORD = merac_pkg::WIDTH_WORD,
  parameter int WIDTH_SEG  = merac_pkg::WIDTH_SEG
) (
  input  logic clk,
  input  logic rst,
  merac_if.slave bus
);
  import merac_pkg::*;

  localparam int NREG = 2**WIDTH_SEG;

  logic [WIDTH_WORD-1:0] regs [NREG];

  // Port 1 is assigned last so it wins when both ports hit the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (bus.write0) regs[bus.srcreg0] <= bus.srcval0;
      if (bus.write1) regs[bus.srcreg1] <= bus.srcval1;
    end
  end

  assign bus.dstval0 = regs[bus.dstreg0];
  assign bus.dstval1 = regs[bus.dstreg1];

  merac_alu #(
    .WIDTH_WORD(WIDTH_WORD)
  ) u_alu (
    .alu_en (bus.alu_en),
    .alu_fn (bus.alu_fn),
    .a      (bus.dstval0),
    .b      (bus.dstval1),
    .retval (bus.retval),
    .carry  (bus.carry)
  );

endmodule

// File: tb/tb_merac_datapath.sv
// Directed and randomized bench for merac_datapath against a behavioural register/ALU model.
module tb_merac_datapath;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] mdl [16];

  merac_if #(.WIDTH_WORD(8), .WIDTH_SEG(4)) bus ();

  merac_datapath #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_ref(input logic en, input logic [2:0] fn,
                                         input int a, input int b);
    int   r;
    logic c;
    r = 0;
    c = 1'b0;
    if (en) begin
      case (fn)
        3'd0: begin r = a + b; c = (r > 255); r = r % 256; end
        3'd1: begin r = (a - b + 256) % 256; c = (a < b); end
        3'd2: r = a | b;
        3'd3: r = (~a) & 255;
        3'd4: r = a;
        3'd5: r = a & b;
        3'd6: r = (a == b) ? 1 : 0;
        default: r = (a < b) ? 1 : 0;
      endcase
    end
    return {c, r[7:0]};
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the currently applied inputs.
  task automatic check_all(input string tag);
    logic [8:0] e;
    e = alu_ref(bus.alu_en, bus.alu_fn, int'(mdl[bus.dstreg0]), int'(mdl[bus.dstreg1]));
    chk8({tag, "_dstval0"}, bus.dstval0, mdl[bus.dstreg0]);
    chk8({tag, "_dstval1"}, bus.dstval1, mdl[bus.dstreg1]);
    chk8({tag, "_retval"},  bus.retval,  e[7:0]);
    chk1({tag, "_carry"},   bus.carry,   e[8]);
  endtask

  // One rising edge; the model commits what the ports present, port 1 last.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (bus.write0) mdl[bus.srcreg0] = bus.srcval0;
      if (bus.write1) mdl[bus.srcreg1] = bus.srcval1;
    end
    #1;
  endtask

  task automatic wr2(input logic [3:0] r0, input logic [7:0] v0,
                     input logic [3:0] r1, input logic [7:0] v1);
    bus.write0 = 1'b1; bus.srcreg0 = r0; bus.srcval0 = v0;
    bus.write1 = 1'b1; bus.srcreg1 = r1; bus.srcval1 = v1;
    step();
    bus.write0 = 1'b0;
    bus.write1 = 1'b0;
  endtask

  task automatic sel(input logic [3:0] d0, input logic [3:0] d1,
                     input logic en, input logic [2:0] fn);
    bus.dstreg0 = d0; bus.dstreg1 = d1; bus.alu_en = en; bus.alu_fn = fn;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    rst = 1'b0;
    bus.write0 = 1'b0; bus.srcreg0 = 4'd0; bus.srcval0 = 8'h00;
    bus.write1 = 1'b0; bus.srcreg1 = 4'd0; bus.srcval1 = 8'h00;
    bus.dstreg0 = 4'd3; bus.dstreg1 = 4'd1; bus.alu_en = 1'b1; bus.alu_fn = 3'd0;

    #1 rst = 1'b1;
    #1;
    chk8("reset_dstval0", bus.dstval0, 8'h00);
    chk8("reset_retval", bus.retval, 8'h00);
    chk1("reset_carry", bus.carry, 1'b0);
    step();
    step();
    #2 rst = 1'b0;

    // Reset pulse between edges clears r3 immediately and blocks a held write.
    bus.write0 = 1'b1; bus.srcreg0 = 4'd3; bus.srcval0 = 8'hAA;
    step();
    bus.write0 = 1'b0;
    chk8("wr_r3_aa", bus.dstval0, 8'hAA);
    bus.write0 = 1'b1; bus.srcval0 = 8'h55;
    #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    #1;
    chk8("rst_async_clear", bus.dstval0, 8'h00);
    step();
    chk8("rst_write_ignored", bus.dstval0, 8'h00);
    #2 rst = 1'b0;
    bus.write0 = 1'b0;
    #1;
    chk8("rst_release_no_write", bus.dstval0, 8'h00);

    // ADD with and without carry.
    wr2(4'd1, 8'd8, 4'd3, 8'd5);
    sel(4'd3, 4'd1, 1'b1, 3'd0);
    chk8("add_13", bus.retval, 8'd13);
    chk1("add_13_c", bus.carry, 1'b0);
    wr2(4'd3, 8'd200, 4'd1, 8'd100);
    chk8("add_44", bus.retval, 8'd44);
    chk1("add_44_c", bus.carry, 1'b1);

    // SUB / LT / EQ.
    wr2(4'd3, 8'd5, 4'd1, 8'd8);
    sel(4'd3, 4'd1, 1'b1, 3'd1);
    chk8("sub_253", bus.retval, 8'd253);
    chk1("sub_borrow", bus.carry, 1'b1);
    sel(4'd3, 4'd1, 1'b1, 3'd7);
    chk8("lt_1", bus.retval, 8'd1);
    chk1("lt_c", bus.carry, 1'b0);
    sel(4'd3, 4'd1, 1'b1, 3'd6);
    chk8("eq_0", bus.retval, 8'd0);
    wr2(4'd3, 8'd7, 4'd1, 8'd7);
    chk8("eq_1", bus.retval, 8'd1);
    sel(4'd3, 4'd1, 1'b1, 3'd1);
    chk8("sub_0", bus.retval, 8'd0);
    chk1("sub_0_c", bus.carry, 1'b0);

    // PC byte pair: new value visible only after the edge.
    sel(4'd14, 4'd15, 1'b1, 3'd4);
    wr2(4'd14, 8'h34, 4'd15, 8'h12);
    chk16("pc_1234", {bus.dstval1, bus.dstval0}, 16'h1234);
    bus.write0 = 1'b1; bus.srcreg0 = 4'd14; bus.srcval0 = 8'h08;
    bus.write1 = 1'b1; bus.srcreg1 = 4'd15; bus.srcval1 = 8'h00;
    #1;
    chk16("pc_before_edge", {bus.dstval1, bus.dstval0}, 16'h1234);
    step();
    bus.write0 = 1'b0; bus.write1 = 1'b0;
    chk16("pc_after_edge", {bus.dstval1, bus.dstval0}, 16'h0008);

    // Same-index collision, then alu_en=0 for every function.
    wr2(4'd5, 8'h11, 4'd5, 8'h22);
    sel(4'd5, 4'd5, 1'b1, 3'd4);
    chk8("collision_r5", bus.dstval0, 8'h22);
    for (int f = 0; f < 8; f++) begin
      sel(4'd5, 4'd5, 1'b0, 3'(f));
      chk8("alu_off_ret", bus.retval, 8'h00);
      chk1("alu_off_c", bus.carry, 1'b0);
    end

    // NOT / MV / OR / AND.
    wr2(4'd3, 8'h0F, 4'd1, 8'hF0);
    sel(4'd3, 4'd1, 1'b1, 3'd3);
    chk8("not", bus.retval, 8'hF0);
    chk1("not_c", bus.carry, 1'b0);
    sel(4'd3, 4'd1, 1'b1, 3'd4);
    chk8("mv", bus.retval, 8'h0F);
    chk1("mv_c", bus.carry, 1'b0);
    sel(4'd3, 4'd1, 1'b1, 3'd2);
    chk8("or", bus.retval, 8'hFF);
    chk1("or_c", bus.carry, 1'b0);
    sel(4'd3, 4'd1, 1'b1, 3'd5);
    chk8("and", bus.retval, 8'h00);
    chk1("and_c", bus.carry, 1'b0);

    // Randomized traffic: outputs checked before each edge, so no bypass is allowed.
    for (int n = 0; n < 300; n++) begin
      bus.write0  = 1'($urandom_range(0, 1));
      bus.srcreg0 = 4'($urandom);
      bus.srcval0 = 8'($urandom);
      bus.write1  = 1'($urandom_range(0, 1));
      bus.srcreg1 = (n % 7 == 0) ? bus.srcreg0 : 4'($urandom);
      bus.srcval1 = 8'($urandom);
      bus.dstreg0 = (n % 5 == 0) ? bus.srcreg0 : 4'($urandom);
      bus.dstreg1 = (n % 11 == 0) ? bus.dstreg0 : 4'($urandom);
      bus.alu_en  = ($urandom_range(0, 7) != 0);
      bus.alu_fn  = 3'($urandom);
      #1;
      check_all("rand");
      step();
    end
    bus.write0 = 1'b0;
    bus.write1 = 1'b0;
    #1;
    check_all("rand_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
